regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
- Initiator side of the register file write port: generates RegWrite/WriteReg/WriteData-style writes for the 32x64 register file.
- Merges two result producers:
  - single-cycle ALU path;
  - variable-latency memory/load path, buffered in a small FIFO.
- Produces at most one registered write per cycle, with a starvation guard so queued load results cannot be blocked forever.

Parameters:
- XLEN, 64, data width of write data and producer results.
- DEPTH, 2, memory-path FIFO entries (power of two, >=2).
- STARVE_LIMIT, 3, cycles a non-empty FIFO head may lose arbitration before the ALU is back-pressured.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result present.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid && alu_ready.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load result present.
- mem_ready  output  1  FIFO can accept a load result.
- mem_rd  input  5  load destination register.
- mem_data  input  XLEN  load result.
- reg_write  output  1  register file write enable (to RegWrite).
- write_reg  output  5  register file write address (to WriteReg).
- write_data  output  XLEN  register file write data (to WriteData).
- fifo_count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- pending  output  1  high when fifo_count != 0.

Behaviour:
- Reset (async assert, sync-released use):
  - reg_write=0, write_reg=0, write_data=0.
  - FIFO pointers and fifo_count=0; FIFO contents discarded; starve counter=0.
  - After reset: mem_ready=1, alu_ready=1, pending=0.
  - Reset mid-operation drops all queued entries; no write is issued for them.
- Handshakes:
  - mem_ready = (fifo_count < DEPTH), from registered state only. No combinational mem_valid->mem_ready path.
  - alu_ready = (starve_cnt < STARVE_LIMIT), from registered state only.
  - alu_valid may be held across cycles while alu_ready=0; inputs must be held stable until accepted.
- Memory path:
  - An accepted mem beat is always enqueued, even if the FIFO is empty; there is no bypass.
  - An entry enqueued on edge N is eligible for arbitration in cycle N+1.
- Arbitration, per cycle, evaluated on the pre-edge state:
  - grant_alu = alu_valid && alu_ready.
  - grant_fifo = !grant_alu && fifo_count != 0.
  - At most one grant per cycle.
- Output stage:
  - On the edge after a grant: write_reg/write_data load the granted rd/data; reg_write = 1 if that rd != 0, else 0.
  - With no grant: reg_write=0; write_reg/write_data hold their previous values.
  - rd==0 results are consumed (handshake completes, FIFO pops) but never raise reg_write.
- Latency:
  - ALU: accepted on edge N, reg_write high in cycle N+1 (1 cycle).
  - Memory: minimum 2 cycles (enqueue edge N, earliest write visible in cycle N+2).
- FIFO occupancy:
  - Push on mem_valid && mem_ready; pop on grant_fifo.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push is impossible when full; pop never occurs when empty.
- Starvation guard:
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle fifo_count != 0 && !grant_fifo.
  - starve_cnt clears to 0 on any grant_fifo, or when fifo_count == 0.
  - While starve_cnt == STARVE_LIMIT: alu_ready=0, so the FIFO head is granted; the counter then clears.
- Ordering:
  - FIFO entries retire strictly in enqueue order.
  - No reordering between ALU and FIFO entries targeting the same rd; WAW ordering is the issuing pipeline's responsibility.

Test Plan:
- After reset, alu_valid=1, alu_rd=1, alu_data=64'hAAAA_AAAA_AAAA_AAAA for one cycle -> next cycle reg_write=1, write_reg=1, write_data=AAAA_AAAA_AAAA_AAAA; the cycle after, reg_write=0.
- ALU idle; mem_valid=1 with rd=2, data=64'h5555_5555_5555_5555 for one cycle -> fifo_count=1, pending=1 for one cycle; write appears 2 cycles after the accept edge; fifo_count returns to 0.
- Three back-to-back mem beats (rd 3,4,5) with DEPTH=2 and alu_valid held high (rd=6) -> mem_ready drops when fifo_count=2; after STARVE_LIMIT=3 lost cycles alu_ready=0 for one cycle and rd=3 is written; the remaining entries drain the same way in order 3,4,5.
- alu_rd=0 with data 64'hFFFF_FFFF_FFFF_FFFF, then mem_rd=0 -> both handshakes complete, FIFO pops, reg_write stays 0 throughout.
- alu_rd=31, data 64'h1234_5678_9ABC_DEF0, in the same cycle as a FIFO pop opportunity with fifo_count=1 and starve_cnt=0 -> ALU wins, write_reg=31; FIFO head is written the following cycle.
- FIFO full (2 entries), rst asserted asynchronously between edges -> reg_write, fifo_count, pending go to 0 immediately; after release mem_ready=1 and no stale writes are issued.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port initiator: merges a single-cycle ALU result stream with a
// FIFO-buffered load stream into one registered write per cycle, with a starvation guard.
module regfile_writeback_arbiter #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [4:0]                   alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [4:0]                   mem_rd,
  input  logic [XLEN-1:0]              mem_data,
  output logic                         reg_write,
  output logic [4:0]                   write_reg,
  output logic [XLEN-1:0]              write_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         pending
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      fifoRd   [DEPTH];
  logic [XLEN-1:0] fifoData [DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic [SW-1:0]   starveCnt;
  logic            push;
  logic            fifoEmpty;
  logic            grantAlu;
  logic            grantFifo;

  // Both ready signals come from registered state only.
  assign mem_ready = fifo_count < CW'(DEPTH);
  assign alu_ready = starveCnt < SW'(STARVE_LIMIT);
  assign fifoEmpty = fifo_count == '0;
  assign pending   = !fifoEmpty;

  assign push      = mem_valid && mem_ready;
  assign grantAlu  = alu_valid && alu_ready;
  assign grantFifo = !grantAlu && !fifoEmpty;

  // Storage needs no reset: occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoRd[wrPtr]   <= mem_rd;
      fifoData[wrPtr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (grantFifo) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, grantFifo})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (fifoEmpty || grantFifo) begin
      starveCnt <= '0;
    end else if (starveCnt < SW'(STARVE_LIMIT)) begin
      starveCnt <= starveCnt + SW'(1);
    end
  end

  // rd 0 is consumed like any other result but never asserts the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (grantAlu) begin
      reg_write  <= alu_rd != 5'd0;
      write_reg  <= alu_rd;
      write_data <= alu_data;
    end else if (grantFifo) begin
      reg_write  <= fifoRd[rdPtr] != 5'd0;
      write_reg  <= fifoRd[rdPtr];
      write_data <= fifoData[rdPtr];
    end else begin
      reg_write  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: per-scenario tasks plus a
// scoreboard of expected write-port activity built from the driven stimulus.
`timescale 1ns/1ps
module tb_regfile_writeback_arbiter;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            reg_write;
  logic [4:0]      write_reg;
  logic [XLEN-1:0] write_data;
  logic [1:0]      fifo_count;
  logic            pending;

  regfile_writeback_arbiter #(.XLEN(XLEN), .DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .fifo_count(fifo_count), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            wr;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wbT;

  wbT memQ[$];
  wbT expQ[$];
  int nCompared   = 0;
  int nMismatched = 0;

  // Called at a negedge with inputs already driven; predicts this cycle's grant,
  // advances one clock, then compares the write port against the prediction.
  task automatic step();
    wbT e;
    e = '0;
    if (alu_valid && alu_ready) begin
      e = '{1'b1, alu_rd, alu_data};
    end else if (memQ.size() != 0) begin
      e = memQ.pop_front();
    end
    if (mem_valid && mem_ready) memQ.push_back('{1'b1, mem_rd, mem_data});
    expQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = expQ.pop_front();
    nCompared++;
    if (e.wr) begin
      if (reg_write !== (e.rd != 5'd0) || write_reg !== e.rd || write_data !== e.data) begin
        nMismatched++;
        $display("FAIL scoreboard_write: got we=%0b rd=%0d data=%h, expected we=%0b rd=%0d data=%h",
                 reg_write, write_reg, write_data, (e.rd != 5'd0), e.rd, e.data);
      end
    end else if (reg_write !== 1'b0) begin
      nMismatched++;
      $display("FAIL scoreboard_idle: got we=%0b rd=%0d, expected we=0", reg_write, write_reg);
    end
  endtask

  task automatic idleInputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nCompared++; if (reg_write !== 1'b0) begin nMismatched++; $display("FAIL reset_reg_write: got %0b expected 0", reg_write); end
    nCompared++; if (write_reg !== 5'd0) begin nMismatched++; $display("FAIL reset_write_reg: got %0d expected 0", write_reg); end
    nCompared++; if (write_data !== 64'd0) begin nMismatched++; $display("FAIL reset_write_data: got %h expected 0", write_data); end
    nCompared++; if (fifo_count !== 2'd0) begin nMismatched++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    nCompared++; if (pending !== 1'b0) begin nMismatched++; $display("FAIL reset_pending: got %0b expected 0", pending); end
    nCompared++; if (mem_ready !== 1'b1) begin nMismatched++; $display("FAIL reset_mem_ready: got %0b expected 1", mem_ready); end
    nCompared++; if (alu_ready !== 1'b1) begin nMismatched++; $display("FAIL reset_alu_ready: got %0b expected 1", alu_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hAAAA_AAAA_AAAA_AAAA;
    step();
    alu_valid = 1'b0;
    nCompared++;
    if (reg_write !== 1'b1 || write_reg !== 5'd1 || write_data !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      nMismatched++; $display("FAIL alu_write: got we=%0b rd=%0d data=%h expected we=1 rd=1 data=aaaaaaaaaaaaaaaa", reg_write, write_reg, write_data);
    end
    step();
    nCompared++;
    if (reg_write !== 1'b0 || write_data !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      nMismatched++; $display("FAIL alu_after: got we=%0b data=%h expected we=0 data held", reg_write, write_data);
    end
  endtask

  task automatic test_mem();
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h5555_5555_5555_5555;
    step();
    mem_valid = 1'b0;
    nCompared++;
    if (fifo_count !== 2'd1 || pending !== 1'b1 || reg_write !== 1'b0) begin
      nMismatched++; $display("FAIL mem_queued: got count=%0d pending=%0b we=%0b expected 1 1 0", fifo_count, pending, reg_write);
    end
    step();
    nCompared++;
    if (reg_write !== 1'b1 || write_reg !== 5'd2 || fifo_count !== 2'd0 || pending !== 1'b0) begin
      nMismatched++; $display("FAIL mem_write: got we=%0b rd=%0d count=%0d pending=%0b expected 1 2 0 0", reg_write, write_reg, fifo_count, pending);
    end
  endtask

  task automatic test_starvation();
    int lost = 0;
    int beat = 0;
    int stalls = 0;
    logic nonEmpty;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h6666_6666_6666_6666;
    for (int c = 0; c < 20; c++) begin
      mem_valid = (beat < 3);
      mem_rd    = 5'(3 + beat);
      mem_data  = 64'hDA7A_0000_0000_0000 + 64'(beat);
      nCompared++;
      if (alu_ready !== (lost < 3)) begin
        nMismatched++; $display("FAIL starve_alu_ready: cycle %0d got %0b expected %0b", c, alu_ready, (lost < 3));
      end
      nCompared++;
      if (mem_ready !== (memQ.size() < 2) || fifo_count !== 2'(memQ.size())) begin
        nMismatched++; $display("FAIL starve_fifo: cycle %0d got ready=%0b count=%0d expected count=%0d", c, mem_ready, fifo_count, memQ.size());
      end
      if (!alu_ready) stalls++;
      nonEmpty = memQ.size() != 0;
      if (!nonEmpty || !(alu_valid && alu_ready)) lost = 0;
      else if (lost < 3) lost++;
      if (mem_valid && mem_ready) beat++;
      step();
    end
    idleInputs();
    nCompared++;
    if (beat !== 3) begin nMismatched++; $display("FAIL starve_beats_accepted: got %0d expected 3", beat); end
    nCompared++;
    if (stalls !== 3) begin nMismatched++; $display("FAIL starve_alu_stalls: got %0d expected 3", stalls); end
    step();
    nCompared++;
    if (fifo_count !== 2'd0 || pending !== 1'b0) begin
      nMismatched++; $display("FAIL starve_drained: got count=%0d pending=%0b expected 0 0", fifo_count, pending);
    end
  endtask

  task automatic test_rd_zero();
    nCompared++;
    if (alu_ready !== 1'b1) begin nMismatched++; $display("FAIL rd0_alu_ready: got %0b expected 1", alu_ready); end
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    alu_valid = 1'b0;
    nCompared++;
    if (reg_write !== 1'b0 || write_reg !== 5'd0) begin
      nMismatched++; $display("FAIL rd0_alu: got we=%0b rd=%0d expected we=0 rd=0", reg_write, write_reg);
    end
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'h0000_0000_0000_0BAD;
    step();
    mem_valid = 1'b0;
    nCompared++;
    if (fifo_count !== 2'd1 || reg_write !== 1'b0) begin
      nMismatched++; $display("FAIL rd0_mem_queued: got count=%0d we=%0b expected 1 0", fifo_count, reg_write);
    end
    step();
    nCompared++;
    if (fifo_count !== 2'd0 || reg_write !== 1'b0) begin
      nMismatched++; $display("FAIL rd0_mem_pop: got count=%0d we=%0b expected 0 0", fifo_count, reg_write);
    end
  endtask

  task automatic test_alu_priority();
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 64'h0000_0000_0000_C0DE;
    step();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 64'h1234_5678_9ABC_DEF0;
    nCompared++;
    if (fifo_count !== 2'd1 || alu_ready !== 1'b1) begin
      nMismatched++; $display("FAIL prio_setup: got count=%0d alu_ready=%0b expected 1 1", fifo_count, alu_ready);
    end
    step();
    alu_valid = 1'b0;
    nCompared++;
    if (reg_write !== 1'b1 || write_reg !== 5'd31 || write_data !== 64'h1234_5678_9ABC_DEF0 || fifo_count !== 2'd1) begin
      nMismatched++; $display("FAIL prio_alu_wins: got we=%0b rd=%0d count=%0d expected 1 31 1", reg_write, write_reg, fifo_count);
    end
    step();
    nCompared++;
    if (reg_write !== 1'b1 || write_reg !== 5'd12 || fifo_count !== 2'd0) begin
      nMismatched++; $display("FAIL prio_fifo_next: got we=%0b rd=%0d count=%0d expected 1 12 0", reg_write, write_reg, fifo_count);
    end
  endtask

  task automatic test_reset_midop();
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 64'h9;
    mem_valid = 1'b1; mem_rd = 5'd7;  mem_data = 64'h7;
    step();
    alu_rd = 5'd10; alu_data = 64'hA;
    mem_rd = 5'd8;  mem_data = 64'h8;
    step();
    idleInputs();
    nCompared++;
    if (fifo_count !== 2'd2 || mem_ready !== 1'b0 || reg_write !== 1'b1) begin
      nMismatched++; $display("FAIL midop_full: got count=%0d mem_ready=%0b we=%0b expected 2 0 1", fifo_count, mem_ready, reg_write);
    end
    #2 rst = 1'b1;
    #1;
    nCompared++;
    if (reg_write !== 1'b0 || fifo_count !== 2'd0 || pending !== 1'b0 || mem_ready !== 1'b1) begin
      nMismatched++; $display("FAIL midop_async_reset: got we=%0b count=%0d pending=%0b mem_ready=%0b expected 0 0 0 1", reg_write, fifo_count, pending, mem_ready);
    end
    memQ.delete();
    expQ.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    nCompared++;
    if (fifo_count !== 2'd0 || mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
      nMismatched++; $display("FAIL midop_after_release: got count=%0d mem_ready=%0b alu_ready=%0b expected 0 1 1", fifo_count, mem_ready, alu_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = '0;
    test_reset();
    test_alu();
    test_mem();
    test_starvation();
    test_rd_zero();
    test_alu_priority();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
